// File: rtl/uart_pkg.sv
// Shared constants and one-hot FSM encodings for the UART word transmitter.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_STOP_TICKS = 16;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

  // Byte FSM, one-hot. S_PARITY is reachable only with UART_WORD_TX_PARITY_EN.
  localparam int B_ST_W = 5;
  localparam logic [B_ST_W-1:0] S_IDLE   = 5'b00001;
  localparam logic [B_ST_W-1:0] S_START  = 5'b00010;
  localparam logic [B_ST_W-1:0] S_DATA   = 5'b00100;
  localparam logic [B_ST_W-1:0] S_PARITY = 5'b01000;
  localparam logic [B_ST_W-1:0] S_STOP   = 5'b10000;

  // Word FSM, one-hot.
  localparam int W_ST_W = 3;
  localparam logic [W_ST_W-1:0] W_IDLE = 3'b001;
  localparam logic [W_ST_W-1:0] W_LOAD = 3'b010;
  localparam logic [W_ST_W-1:0] W_WAIT = 3'b100;

endpackage

// File: rtl/uart_tx_byte.sv
// Single UART frame serializer: start, BYTE_WIDTH data bits LSB first, optional even
// parity (UART_WORD_TX_PARITY_EN), stop. o_tx is registered; o_done pulses after the stop bit.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int STOP_TICKS = DEF_STOP_TICKS
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_tick,
  input  logic                  i_start,
  input  logic [BYTE_WIDTH-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_done
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX);
  localparam int BIT_W    = $clog2(BYTE_WIDTH);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BYTE_WIDTH - 1);

  logic [B_ST_W-1:0]     state;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BYTE_WIDTH-1:0] shift;
`ifdef UART_WORD_TX_PARITY_EN
  logic                  parity;
`endif

  // o_tx always carries the value of the bit being sent; it is updated on the same edge
  // the state changes, so every bit boundary is a single registered transition.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_WORD_TX_PARITY_EN
      parity   <= 1'b0;
`endif
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_tx <= 1'b1;
          if (i_start) begin
            state    <= S_START;
            shift    <= i_data;
`ifdef UART_WORD_TX_PARITY_EN
            parity   <= ^i_data;
`endif
            tick_cnt <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b0;
          end
        end
        S_START: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= S_DATA;
              o_tx     <= shift[0];
              shift    <= shift >> 1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
`ifdef UART_WORD_TX_PARITY_EN
                state <= S_PARITY;
                o_tx  <= parity;
`else
                state <= S_STOP;
                o_tx  <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                o_tx    <= shift[0];
                shift   <= shift >> 1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_WORD_TX_PARITY_EN
        S_PARITY: begin
          if (i_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= S_STOP;
              o_tx     <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (i_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              state    <= S_IDLE;
              o_tx     <= 1'b1;
              o_done   <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          tick_cnt <= '0;
          o_tx     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx_buffer.sv
// Sends each accepted word as BYTES_PER_WORD UART frames, MSB byte first.
// Optional even parity bit per frame when UART_WORD_TX_PARITY_EN is defined.
module uart_word_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int STOP_TICKS = DEF_STOP_TICKS
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_tick,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_start,
  output logic                  o_empty,
  output logic                  o_word_done,
  output logic                  o_tx
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [W_ST_W-1:0]     word_state;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [IDX_W-1:0]      byte_idx;
  logic                  byte_start;
  logic                  byte_done;

  // Handshake: a word is taken on any edge where i_start=1 and o_empty=1; o_empty drops
  // on the next cycle and rises again together with the o_word_done pulse. i_start while
  // busy is dropped.
  assign o_empty    = (word_state == W_IDLE);
  assign byte_start = (word_state == W_LOAD);

  // word_reg shifts left after each load, so the current byte is always the top slice.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_state  <= W_IDLE;
      word_reg    <= '0;
      byte_idx    <= '0;
      o_word_done <= 1'b0;
    end else begin
      o_word_done <= 1'b0;
      case (word_state)
        W_IDLE: begin
          if (i_start) begin
            word_reg   <= i_word;
            byte_idx   <= '0;
            word_state <= W_LOAD;
          end
        end
        W_LOAD: begin
          word_reg   <= word_reg << BYTE_WIDTH;
          word_state <= W_WAIT;
        end
        W_WAIT: begin
          if (byte_done) begin
            if (byte_idx == LAST_IDX) begin
              word_state  <= W_IDLE;
              o_word_done <= 1'b1;
            end else begin
              byte_idx   <= byte_idx + 1'b1;
              word_state <= W_LOAD;
            end
          end
        end
        default: word_state <= W_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .OVERSAMPLE (OVERSAMPLE),
    .STOP_TICKS (STOP_TICKS)
  ) u_tx_byte (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_tick    (i_tick),
    .i_start   (byte_start),
    .i_data    (word_reg[DATA_WIDTH-1 -: BYTE_WIDTH]),
    .o_tx      (o_tx),
    .o_done    (byte_done)
  );

endmodule
